// File: rtl/qmult_pipe.sv
// qmult_pipe: pipelined sign-magnitude fixed-point multiplier with valid/ready
// handshake, optional round-half-up and a sticky overflow flag.
// Optional feature: define QMULT_SAT_EN to saturate overflowed products to the
// largest magnitude; without it the magnitude wraps to N-1 bits.
// Pipeline: STAGES-1 product stages followed by one formatted output register.
module qmult_pipe #(
  parameter int N      = 32,
  parameter int Q      = 16,
  parameter int STAGES = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_multiplicand,
  input  logic [N-1:0] i_multiplier,
  input  logic         i_round_en,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_result,
  output logic         o_ovr,
  input  logic         i_clr_sticky,
  output logic         o_ovr_sticky
);

  // Full magnitude product width, and the slice kept from the round bit upward
  localparam int PW = 2 * (N - 1);
  localparam int PT = PW - Q + 1;
  localparam int D  = STAGES - 1;

  logic          stall;
  logic [PT-1:0] prod_top;
  logic [PT-1:0] prod_reg [D];
  logic [D-1:0]  sign_reg;
  logic [D-1:0]  round_reg;
  logic [D-1:0]  valid_reg;

  logic [PT-1:0] p_last;
  logic [N-2:0]  m_raw;
  logic [N-1:0]  m_sum;
  logic          inc;
  logic          ovr;
  logic [N-2:0]  mag;
  logic          sign;

  logic          out_valid_reg;
  logic [N-1:0]  result_reg;
  logic          ovr_reg;
  logic          sticky_reg;

  assign stall   = out_valid_reg & ~i_ready;
  assign o_ready = ~stall;

  // Bits below the round position never influence the result, so only the
  // product from bit Q-1 upward is carried through the pipeline.
  assign prod_top = PT'(({{(N-1){1'b0}}, i_multiplicand[N-2:0]} *
                         {{(N-1){1'b0}}, i_multiplier[N-2:0]}) >> (Q - 1));

  // Product delay line; every stage freezes while the output is stalled
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < D; i++) prod_reg[i] <= '0;
      sign_reg  <= '0;
      round_reg <= '0;
      valid_reg <= '0;
    end else if (!stall) begin
      prod_reg[0]  <= prod_top;
      sign_reg[0]  <= i_multiplicand[N-1] ^ i_multiplier[N-1];
      round_reg[0] <= i_round_en;
      valid_reg[0] <= i_valid;
      for (int i = 1; i < D; i++) begin
        prod_reg[i]  <= prod_reg[i-1];
        sign_reg[i]  <= sign_reg[i-1];
        round_reg[i] <= round_reg[i-1];
        valid_reg[i] <= valid_reg[i-1];
      end
    end
  end

  assign p_last = prod_reg[D-1];

  // Magnitude extraction, rounding, overflow detection and zero-sign cleanup
  always_comb begin
    m_raw = p_last[N-1:1];
    inc   = round_reg[D-1] & p_last[0];
    m_sum = {1'b0, m_raw} + {{(N-1){1'b0}}, inc};
    ovr   = (|p_last[PT-1:N]) | m_sum[N-1];
`ifdef QMULT_SAT_EN
    mag   = ovr ? '1 : m_sum[N-2:0];
`else
    mag   = m_sum[N-2:0];
`endif
    sign  = sign_reg[D-1] & (|mag);
  end

  // Output register; holds its product while downstream is not ready
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      ovr_reg       <= 1'b0;
    end else if (!stall) begin
      out_valid_reg <= valid_reg[D-1];
      result_reg    <= {sign, mag};
      ovr_reg       <= ovr;
    end
  end

  // Sticky overflow: an overflowed handoff wins over a simultaneous clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sticky_reg <= 1'b0;
    end else if (out_valid_reg && i_ready && ovr_reg) begin
      sticky_reg <= 1'b1;
    end else if (i_clr_sticky) begin
      sticky_reg <= 1'b0;
    end
  end

  assign o_valid      = out_valid_reg;
  assign o_result     = result_reg;
  assign o_ovr        = ovr_reg;
  assign o_ovr_sticky = sticky_reg;

endmodule

// File: doc/qmult_pipe.md
QMULT_PIPE -- requirements
Module: qmult_pipe

Interface
REQ-001 The block SHALL have parameter N, default 32, total word width in bits, N >= 4.
REQ-002 The block SHALL have parameter Q, default 16, fractional bit count, 1 <= Q <= N-2.
REQ-003 The block SHALL have parameter STAGES, default 3, register stages from input accept to output valid, STAGES >= 2.
REQ-004 i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 i_rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 i_valid  input  1  operand pair present on i_multiplicand/i_multiplier.
REQ-007 o_ready  output  1  block accepts operands this cycle.
REQ-008 i_multiplicand  input  N  sign-magnitude fixed-point operand A: bit N-1 sign, bits N-2:0 magnitude with Q fractional bits.
REQ-009 i_multiplier  input  N  sign-magnitude fixed-point operand B, same format as A.
REQ-010 i_round_en  input  1  round-half-up on the discarded fraction, sampled with the operands.
REQ-011 o_valid  output  1  o_result/o_ovr hold a product.
REQ-012 i_ready  input  1  downstream accepts the product this cycle.
REQ-013 o_result  output  N  product in the operand format.
REQ-014 o_ovr  output  1  overflow flag of the product currently on o_result.
REQ-015 i_clr_sticky  input  1  clears o_ovr_sticky.
REQ-016 o_ovr_sticky  output  1  set when any overflowed product has been handed off.

Function
REQ-017 Accept SHALL occur when i_valid && o_ready; handoff SHALL occur when o_valid && i_ready.
REQ-018 Stall = o_valid && !i_ready; o_ready SHALL equal !stall; on stall every pipeline stage (data, valid, round flag) SHALL hold.
REQ-019 Without stall, a product accepted in cycle t SHALL appear with o_valid=1 in cycle t+STAGES; throughput one product per cycle.
REQ-020 o_result, o_ovr SHALL stay stable while o_valid && !i_ready.
REQ-021 Magnitude product P = A[N-2:0] * B[N-2:0], width 2N-2, unsigned.
REQ-022 Raw magnitude M = P[N-2+Q:Q]; if round flag set, M SHALL be incremented by P[Q-1].
REQ-023 o_ovr SHALL be 1 if P[2N-3:N-1+Q] is non-zero or the rounding increment carries out of N-1 bits.
REQ-024 Sign SHALL be A[N-1] XOR B[N-1], forced to 0 when the final magnitude is zero (no negative zero).
REQ-025 Bubbles (i_valid=0) SHALL propagate as o_valid=0 with no effect on o_ovr_sticky.
REQ-026 o_ovr_sticky SHALL set on a handoff with o_ovr=1, clear on i_clr_sticky; set and clear in the same cycle SHALL leave it 1.

Reset
REQ-027 While i_rst_n=0: every stage valid=0, o_valid=0, o_result=0, o_ovr=0, o_ovr_sticky=0, o_ready=1.
REQ-028 Reset mid-operation SHALL discard all in-flight products; none SHALL appear after release.
REQ-029 First accept SHALL be possible in the first rising edge after i_rst_n rises.

Configuration
REQ-030 With QMULT_SAT_EN defined, an overflowed product SHALL output magnitude all ones (2^(N-1)-1) with the REQ-024 sign, and o_ovr=1.
REQ-031 Without QMULT_SAT_EN, an overflowed product SHALL output the REQ-022 bits truncated to N-1, o_ovr=1; no saturation logic synthesised.

Verification (N=32, Q=16, STAGES=3)
REQ-032 0x00018000 x 0x00020000, round off -> 0x00030000, o_ovr=0, o_valid exactly 3 cycles after accept; 0x80018000 x 0x00020000 -> 0x80030000.
REQ-033 0x40000000 x 0x00040000 -> o_ovr=1, o_ovr_sticky=1 after handoff; with QMULT_SAT_EN 0x7FFFFFFF, without 0x00000000.
REQ-034 0x00000001 x 0x00008000: round on -> 0x00000001; round off -> 0x00000000; 0x80000001 x 0x00000001 round off -> 0x00000000 (sign cleared).
REQ-035 Stream 6 back-to-back products, hold i_ready=0 for 4 cycles mid-stream -> o_ready=0 during stall, o_result stable, all 6 results in order, none lost or duplicated.
REQ-036 Assert i_rst_n=0 with 2 products in flight -> o_valid=0 immediately, no products after release; i_clr_sticky with simultaneous overflowed handoff -> o_ovr_sticky=1.
